// File: rtl/mmio_io_hub.sv
// mmio_io_hub -- memory-mapped peripheral hub on the CPU data port.
// Switch banks, LED banks, a 7-seg register, button press capture and a
// keyboard FIFO, all behind a registered (1-cycle latency) read port.
// Build option: define MMIO_TIMER_EN to add a free-running cycle counter
// (0x98), a compare register (0x9C) and the timer_irq output.
module mmio_io_hub #(
  parameter int SW_NUM   = 3,
  parameter int SW_W     = 8,
  parameter int LED_NUM  = 2,
  parameter int LED_W    = 8,
  parameter int BTN_NUM  = 5,
  parameter int KB_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sel,
  input  logic [7:0]               addr,
  input  logic                     rd_en,
  input  logic                     wr_en,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  output logic [31:0]              rdata,
  output logic                     rvalid,
  output logic                     addr_err,
  input  logic [SW_NUM*SW_W-1:0]   switches,
  input  logic [BTN_NUM-1:0]       btn,
  input  logic                     kb_valid,
  input  logic [3:0]               kb_code,
  output logic [LED_NUM*LED_W-1:0] led_out,
  output logic [31:0]              seg_out,
  output logic                     kb_irq
`ifdef MMIO_TIMER_EN
  ,
  output logic                     timer_irq
`endif
);

  localparam int PTR_W = (KB_DEPTH > 1) ? $clog2(KB_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [7:0] OFF_LED_BASE  = 8'h40;
  localparam logic [7:0] OFF_BTN_RAW   = 8'h80;
  localparam logic [7:0] OFF_BTN_PRESS = 8'h84;
  localparam logic [7:0] OFF_SEG       = 8'h88;
  localparam logic [7:0] OFF_KB_STAT   = 8'h8C;
  localparam logic [7:0] OFF_KB_POP    = 8'h90;
`ifdef MMIO_TIMER_EN
  localparam logic [7:0] OFF_TMR_CNT   = 8'h98;
  localparam logic [7:0] OFF_TMR_CMP   = 8'h9C;
`endif

  // Byte-lane merge: strobed bytes take the new data, others keep the old.
  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] nxt,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = nxt[8*b +: 8];
    return res;
  endfunction

  // Access decode; addr[1:0] carries no information for word accesses.
  logic [7:0] off;
  logic       acc, wr, rd;
  logic       unused_addr_bits;
  assign off              = {addr[7:2], 2'b00};
  assign acc              = sel & (rd_en | wr_en);
  assign wr               = sel & wr_en;
  assign rd               = sel & rd_en & ~wr_en;
  assign unused_addr_bits = ^addr[1:0];

  // State
  logic [LED_W-1:0]   led_q [LED_NUM];
  logic [31:0]        seg_q;
  logic [BTN_NUM-1:0] btn_q, btn_press;
  logic [3:0]         kb_mem [KB_DEPTH];
  logic [PTR_W-1:0]   kb_rd_ptr, kb_wr_ptr;
  logic [CNT_W-1:0]   kb_count, kb_count_next;
  logic               kb_ovf;
`ifdef MMIO_TIMER_EN
  logic [31:0]        tmr_cnt, tmr_cmp;
`endif

  logic kb_empty, kb_full, kb_pop, kb_push, kb_drop;
  assign kb_empty = (kb_count == '0);
  assign kb_full  = (kb_count == CNT_W'(KB_DEPTH));
  assign kb_pop   = rd && (off == OFF_KB_POP) && !kb_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign kb_push  = kb_valid && (!kb_full || kb_pop);
  assign kb_drop  = kb_valid && !kb_push;

  // Address map lookup: mapped flag and read value for the current offset.
  logic        mapped;
  logic [31:0] rd_val;
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // so no path through the block can leave it unassigned (no latch).
    mapped = 1'b0;
    rd_val = '0;
    for (int i = 0; i < SW_NUM; i++)
      if (off == 8'(4 * i)) begin
        mapped = 1'b1;
        rd_val = 32'(switches[i*SW_W +: SW_W]);
      end
    for (int i = 0; i < LED_NUM; i++)
      if (off == OFF_LED_BASE + 8'(4 * i)) begin
        mapped = 1'b1;
        rd_val = 32'(led_q[i]);
      end
    case (off)
      OFF_BTN_RAW:   begin mapped = 1'b1; rd_val = 32'(btn);       end
      OFF_BTN_PRESS: begin mapped = 1'b1; rd_val = 32'(btn_press); end
      OFF_SEG:       begin mapped = 1'b1; rd_val = seg_q;          end
      OFF_KB_STAT: begin
        mapped = 1'b1;
        rd_val = {20'b0, 8'(kb_count), 1'b0, kb_ovf, kb_full, kb_empty};
      end
      OFF_KB_POP: begin
        mapped = 1'b1;
        rd_val = kb_empty ? 32'h0 : {23'b0, 1'b1, 4'b0, kb_mem[kb_rd_ptr]};
      end
`ifdef MMIO_TIMER_EN
      OFF_TMR_CNT:   begin mapped = 1'b1; rd_val = tmr_cnt; end
      OFF_TMR_CMP:   begin mapped = 1'b1; rd_val = tmr_cmp; end
`endif
      default: ;
    endcase
  end

  // Registered read response and unmapped-access pulse.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      rvalid   <= 1'b0;
      addr_err <= 1'b0;
      rdata    <= '0;
    end else begin
      rvalid   <= rd;
      addr_err <= acc & ~mapped;
      if (rd) rdata <= rd_val;
    end
  end

  // LED and 7-seg write registers with byte enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LED_NUM; i++) led_q[i] <= '0;
      seg_q <= '0;
    end else if (wr) begin
      for (int i = 0; i < LED_NUM; i++)
        if (off == OFF_LED_BASE + 8'(4 * i))
          led_q[i] <= LED_W'(apply_strb(32'(led_q[i]), wdata, wstrb));
      if (off == OFF_SEG) seg_q <= apply_strb(seg_q, wdata, wstrb);
    end
  end

  // Flatten LED banks onto the output bus.
  always_comb begin
    led_out = '0;
    for (int i = 0; i < LED_NUM; i++) led_out[i*LED_W +: LED_W] = led_q[i];
  end
  assign seg_out = seg_q;

  // Button rise capture; a fresh edge survives a clearing read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q     <= '0;
      btn_press <= '0;
    end else begin
      btn_q     <= btn;
      btn_press <= ((rd && off == OFF_BTN_PRESS) ? '0 : btn_press) | (btn & ~btn_q);
    end
  end

  // FIFO occupancy after this edge, used for the registered interrupt.
  always_comb begin
    kb_count_next = kb_count;
    if (kb_push && !kb_pop)      kb_count_next = kb_count + CNT_W'(1);
    else if (!kb_push && kb_pop) kb_count_next = kb_count - CNT_W'(1);
  end

  // Keyboard FIFO pointers, count, overflow flag and interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kb_rd_ptr <= '0;
      kb_wr_ptr <= '0;
      kb_count  <= '0;
      kb_ovf    <= 1'b0;
      kb_irq    <= 1'b0;
    end else begin
      if (kb_pop)  kb_rd_ptr <= kb_rd_ptr + PTR_W'(1);
      if (kb_push) kb_wr_ptr <= kb_wr_ptr + PTR_W'(1);
      kb_count <= kb_count_next;
      kb_ovf   <= ((rd && off == OFF_KB_STAT) ? 1'b0 : kb_ovf) | kb_drop;
      kb_irq   <= (kb_count_next != '0);
    end
  end

  // Keyboard FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the pointers and count define which
    // entries are live, so clearing them is enough to discard contents.
    if (kb_push) kb_mem[kb_wr_ptr] <= kb_code;
  end

`ifdef MMIO_TIMER_EN
  // Free-running cycle counter (loadable) and compare register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_cnt <= '0;
      tmr_cmp <= '0;
    end else begin
      if (wr && off == OFF_TMR_CNT) tmr_cnt <= apply_strb(tmr_cnt, wdata, wstrb);
      else                          tmr_cnt <= tmr_cnt + 32'd1;
      if (wr && off == OFF_TMR_CMP) tmr_cmp <= apply_strb(tmr_cmp, wdata, wstrb);
    end
  end

  assign timer_irq = (tmr_cnt >= tmr_cmp) && (tmr_cmp != '0);
`endif

endmodule
